// File: rtl/frame_buffer_pkg.sv
// Shared types and address helpers for the frame buffer source.
// Coordinates are 16-bit; range checks happen before any address arithmetic.
package frame_buffer_pkg;

  localparam int COORD_W = 16;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  function automatic logic in_range(input logic [COORD_W-1:0] row,
                                    input logic [COORD_W-1:0] col,
                                    input int h_res, input int v_res);
    return (int'(row) < v_res) && (int'(col) < h_res);
  endfunction

  function automatic logic [31:0] pix_addr(input logic [COORD_W-1:0] row,
                                           input logic [COORD_W-1:0] col,
                                           input int h_res);
    return int'(row) * h_res + int'(col);
  endfunction

endpackage

// File: rtl/frame_buffer_source_if.sv
// Pixel fetch, pixel write and control signals between the display path and the frame buffer.
interface frame_buffer_source_if #(parameter int COLOR_BITS = 1);

  logic                                  enable;
  logic                                  rd_valid;
  logic [frame_buffer_pkg::COORD_W-1:0]  row;
  logic [frame_buffer_pkg::COORD_W-1:0]  column;
  logic [COLOR_BITS-1:0]                 r;
  logic [COLOR_BITS-1:0]                 g;
  logic [COLOR_BITS-1:0]                 b;
  logic                                  pix_valid;
  logic                                  wr_valid;
  logic                                  wr_ready;
  logic [frame_buffer_pkg::COORD_W-1:0]  wr_row;
  logic [frame_buffer_pkg::COORD_W-1:0]  wr_col;
  logic [3*COLOR_BITS-1:0]               wr_rgb;
  logic                                  clear_req;
  logic                                  clear_busy;
  logic                                  swap_req;
  logic                                  frame_start;

  modport master (
    output enable, rd_valid, row, column, wr_valid, wr_row, wr_col, wr_rgb,
           clear_req, swap_req, frame_start,
    input  r, g, b, pix_valid, wr_ready, clear_busy
  );

  modport slave (
    input  enable, rd_valid, row, column, wr_valid, wr_row, wr_col, wr_rgb,
           clear_req, swap_req, frame_start,
    output r, g, b, pix_valid, wr_ready, clear_busy
  );

endinterface

// File: rtl/fb_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read-first read port.
// Latency: read data one cycle after raddr.
// Backpressure: none; both ports accept every cycle.
module fb_ram #(
  parameter int WORD_W = 3,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Non-blocking update gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_source.sv
// Writable RGB frame buffer; FRAME_BUFFER_DOUBLE_BUFFER_EN adds a back bank with frame-aligned swap.
// Latency: pixel fetch result 2 cycles after rd_valid.
// Backpressure: wr_ready low only while a clear sweep runs; reads never stall.
module frame_buffer_source
  import frame_buffer_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COLOR_BITS = 1
) (
  input logic                  clk,
  input logic                  reset,
  frame_buffer_source_if.slave fb
);

  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
  localparam int NBANKS = 2;
`else
  localparam int NBANKS = 1;
`endif
  localparam int TOTAL  = NBANKS * DEPTH;
  localparam int RAM_AW = $clog2(TOTAL);
  localparam int WORD_W = 3 * COLOR_BITS;

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } pixel_t;

  function automatic logic [RAM_AW-1:0] bank_addr(input logic sel, input logic [ADDR_W-1:0] off);
    return sel ? RAM_AW'(DEPTH) + RAM_AW'(off) : RAM_AW'(off);
  endfunction

  state_t             state_q, state_d;
  logic [RAM_AW-1:0]  cnt_q, cnt_d;
  logic               clr_all_q, clr_all_d;
  logic               clr_last;
  logic               clear_busy;
  logic               front_sel, back_sel;

  // Bank selection: reads from the front bank, writes and clears hit the back bank.
`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
  logic swap_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_sel <= 1'b0;
      swap_pend <= 1'b0;
    end else if (fb.frame_start && (swap_pend || fb.swap_req) && state_q == ST_IDLE) begin
      front_sel <= ~front_sel;
      swap_pend <= 1'b0;
    end else if (fb.swap_req) begin
      swap_pend <= 1'b1;
    end
  end
  assign back_sel = ~front_sel;
`else
  logic unused_swap;
  assign front_sel   = 1'b0;
  assign back_sel    = 1'b0;
  assign unused_swap = fb.swap_req ^ fb.frame_start;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      clr_all_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_all_q <= clr_all_d;
    end
  end

  // The post-reset sweep covers every bank; a requested clear covers only the back bank.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_all_d = clr_all_q;
    clr_last  = clr_all_q ? (cnt_q == RAM_AW'(TOTAL - 1)) : (cnt_q == RAM_AW'(DEPTH - 1));
    case (state_q)
      ST_IDLE: begin
        if (fb.clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_last) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          clr_all_d = 1'b0;
        end else begin
          cnt_d = cnt_q + RAM_AW'(1);
        end
      end
    endcase
  end

  assign clear_busy    = (state_q == ST_CLEAR);
  assign fb.clear_busy = clear_busy;
  assign fb.wr_ready   = (state_q == ST_IDLE);

  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] wr_off, rd_off;
  logic              wr_hit;

  // Out-of-range writes still complete the handshake but never reach the RAM.
  assign wr_hit    = fb.wr_valid && !clear_busy && in_range(fb.wr_row, fb.wr_col, H_RES, V_RES);
  assign wr_off    = ADDR_W'(pix_addr(fb.wr_row, fb.wr_col, H_RES));
  assign rd_off    = ADDR_W'(pix_addr(fb.row, fb.column, H_RES));
  assign ram_we    = clear_busy || wr_hit;
  assign ram_waddr = !clear_busy ? bank_addr(back_sel, wr_off)
                   : clr_all_q   ? cnt_q
                   :               bank_addr(back_sel, ADDR_W'(cnt_q));
  assign ram_wdata = clear_busy ? '0 : fb.wr_rgb;
  assign ram_raddr = bank_addr(front_sel, rd_off);

  fb_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (TOTAL),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  logic   vld1_q, ok1_q, pix_vld_q;
  pixel_t pix_q;

  // Stage 1 runs alongside the RAM read; stage 2 masks and registers the colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld1_q    <= 1'b0;
      ok1_q     <= 1'b0;
      pix_vld_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      vld1_q    <= fb.rd_valid;
      ok1_q     <= fb.rd_valid && !clear_busy && in_range(fb.row, fb.column, H_RES, V_RES);
      pix_vld_q <= vld1_q;
      pix_q     <= (ok1_q && fb.enable) ? pixel_t'(ram_rdata) : '0;
    end
  end

  assign fb.r         = pix_q.r;
  assign fb.g         = pix_q.g;
  assign fb.b         = pix_q.b;
  assign fb.pix_valid = pix_vld_q;

endmodule
